adder_multiword_seq: RTL and testbench



---
 rtl/adder_multiword_seq_pkg.sv | 17 +
 rtl/adder_multiword_seq_if.sv | 41 ++++
 rtl/adder_multiword_seq_slice_step.sv | 39 +++
 rtl/adder_multiword_seq.sv | 126 ++++++++++++
 tb/tb_adder_multiword_seq.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_multiword_seq_pkg.sv
// Shared types and reset constants for the multi-word sequential adder.
// Optional feature macro: ADDER_MULTIWORD_SUB_EN (adds subtract mode).
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_READY = 1'b1;
    localparam logic   RST_VALID = 1'b0;
    localparam logic   RST_BUSY  = 1'b0;
    localparam logic   RST_CRY   = 1'b0;

endpackage

// File: rtl/adder_multiword_seq_if.sv
// Operand/result handshake bundle for adder_multiword_seq.
// Optional feature macro: ADDER_MULTIWORD_SUB_EN (adds i_sub).
interface adder_multiword_seq_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WORD_NUM   = 4
);
    localparam int unsigned TOTAL_WIDTH = DATA_WIDTH * WORD_NUM;

    logic                   i_valid;
    logic                   o_ready;
    logic [TOTAL_WIDTH-1:0] i_num_a;
    logic [TOTAL_WIDTH-1:0] i_num_b;
    logic                   i_cry;
`ifdef ADDER_MULTIWORD_SUB_EN
    logic                   i_sub;
`endif
    logic                   o_valid;
    logic                   i_ready;
    logic [TOTAL_WIDTH-1:0] o_res;
    logic                   o_cry;
    logic                   o_busy;

    // Adder side
    modport slave (
        input  i_valid, i_num_a, i_num_b, i_cry, i_ready,
`ifdef ADDER_MULTIWORD_SUB_EN
        input  i_sub,
`endif
        output o_ready, o_valid, o_res, o_cry, o_busy
    );

    // Operand source / result consumer side
    modport master (
        output i_valid, i_num_a, i_num_b, i_cry, i_ready,
`ifdef ADDER_MULTIWORD_SUB_EN
        output i_sub,
`endif
        input  o_ready, o_valid, o_res, o_cry, o_busy
    );

endinterface

// File: rtl/adder_multiword_seq_slice_step.sv
// Combinational DATA_WIDTH slice adder built from 4-bit carry-lookahead cells.
module adder_slice_step #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_cry,
    output logic [DATA_WIDTH-1:0] o_sum_c,
    output logic                  o_cry_c
);
    localparam int unsigned CELL_NUM = DATA_WIDTH / 4;

    logic [CELL_NUM:0] w_cry;

    assign w_cry[0] = i_cry;
    assign o_cry_c  = w_cry[CELL_NUM];

    // One lookahead cell per nibble; cells chain through w_cry
    for (genvar gi = 0; gi < CELL_NUM; gi++) begin : g_cell
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [4:0] w_c;

        assign w_g    = i_a[gi*4 +: 4] & i_b[gi*4 +: 4];
        assign w_p    = i_a[gi*4 +: 4] ^ i_b[gi*4 +: 4];
        assign w_c[0] = w_cry[gi];
        assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                      | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                      | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                      | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

        assign o_sum_c[gi*4 +: 4] = w_p ^ w_c[3:0];
        assign w_cry[gi+1]        = w_c[4];
    end

endmodule

// File: rtl/adder_multiword_seq.sv
// Multi-cycle wide adder: one DATA_WIDTH slice per clock, carry kept in a register.
// Optional feature macro: ADDER_MULTIWORD_SUB_EN (a - b - borrow via i_sub).
module adder_multiword_seq
    import adder_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WORD_NUM   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    adder_multiword_seq_if.slave bus
);
    localparam int unsigned TOTAL_WIDTH = DATA_WIDTH * WORD_NUM;
    localparam int unsigned IDX_W       = $clog2(WORD_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_NUM - 1);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_cry;
    logic [TOTAL_WIDTH-1:0] r_a;
    logic [TOTAL_WIDTH-1:0] r_b;
    logic [TOTAL_WIDTH-1:0] r_res;
    logic                   r_cry_out;
    logic                   r_valid;
    logic                   r_ready;
    logic                   r_busy;
`ifdef ADDER_MULTIWORD_SUB_EN
    logic                   r_sub;
`endif

    logic [DATA_WIDTH-1:0]  w_a_slice;
    logic [DATA_WIDTH-1:0]  w_b_slice;
    logic [DATA_WIDTH-1:0]  w_sum;
    logic                   w_slice_cry;

    // Select the operand slice addressed by the index; invert b when subtracting
    assign w_a_slice = r_a[r_idx*DATA_WIDTH +: DATA_WIDTH];
`ifdef ADDER_MULTIWORD_SUB_EN
    assign w_b_slice = r_b[r_idx*DATA_WIDTH +: DATA_WIDTH] ^ {DATA_WIDTH{r_sub}};
`else
    assign w_b_slice = r_b[r_idx*DATA_WIDTH +: DATA_WIDTH];
`endif

    adder_slice_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slice (
        .i_a     (w_a_slice),
        .i_b     (w_b_slice),
        .i_cry   (r_cry),
        .o_sum_c (w_sum),
        .o_cry_c (w_slice_cry)
    );

    assign bus.o_ready = r_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = r_busy;
    assign bus.o_res   = r_res;
    assign bus.o_cry   = r_cry_out;

    // Control FSM with index counter, carry register and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= RST_STATE;
            r_idx     <= '0;
            r_cry     <= RST_CRY;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_cry_out <= RST_CRY;
            r_valid   <= RST_VALID;
            r_ready   <= RST_READY;
            r_busy    <= RST_BUSY;
`ifdef ADDER_MULTIWORD_SUB_EN
            r_sub     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_valid) begin
                        r_a       <= bus.i_num_a;
                        r_b       <= bus.i_num_b;
`ifdef ADDER_MULTIWORD_SUB_EN
                        r_sub     <= bus.i_sub;
                        r_cry     <= bus.i_sub ? ~bus.i_cry : bus.i_cry;
`else
                        r_cry     <= bus.i_cry;
`endif
                        r_res     <= '0;
                        r_cry_out <= 1'b0;
                        r_idx     <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= CALC;
                    end
                end
                CALC: begin
                    r_res[r_idx*DATA_WIDTH +: DATA_WIDTH] <= w_sum;
                    r_cry <= w_slice_cry;
                    if (r_idx == LAST_IDX) begin
                        r_cry_out <= w_slice_cry;
                        r_idx     <= '0;
                        r_busy    <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= RST_VALID;
                    r_ready <= RST_READY;
                    r_busy  <= RST_BUSY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_multiword_seq.sv
// Self-checking bench for adder_multiword_seq (DATA_WIDTH=8, WORD_NUM=4).
// Optional feature macro: ADDER_MULTIWORD_SUB_EN (subtract vectors).
module tb_adder_multiword_seq;

    localparam int unsigned DW = 8;
    localparam int unsigned WN = 4;
    localparam int unsigned TW = DW * WN;

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          cin;
        logic          sub;
        int            hold;
        logic [TW-1:0] exp_res;
        logic          exp_cry;
    } vec_t;

    typedef struct {
        logic [TW-1:0] res;
        logic          cry;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    vec_t vecs[$];

    adder_multiword_seq_if #(.DATA_WIDTH(DW), .WORD_NUM(WN)) bus ();

    adder_multiword_seq #(
        .DATA_WIDTH (DW),
        .WORD_NUM   (WN)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference; subtraction done as a true borrow subtract
    function automatic exp_t model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [TW:0] t;
        if (sub) begin
            t     = {1'b0, a} - {1'b0, b} - (TW+1)'(cin);
            e.res = t[TW-1:0];
            e.cry = ~t[TW];
        end else begin
            t     = {1'b0, a} + {1'b0, b} + (TW+1)'(cin);
            e.res = t[TW-1:0];
            e.cry = t[TW];
        end
        return e;
    endfunction

    task automatic run_op(input vec_t v);
        int            cyc;
        exp_t          e;
        logic [TW-1:0] held_res;
        logic          held_cry;
        bus.i_ready = (v.hold == 0);
        cyc = 0;
        while (!bus.o_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_accept", 64'(bus.o_ready), 64'(1));
        bus.i_num_a = v.a;
        bus.i_num_b = v.b;
        bus.i_cry   = v.cin;
`ifdef ADDER_MULTIWORD_SUB_EN
        bus.i_sub   = v.sub;
`endif
        bus.i_valid = 1'b1;
        e.res = v.exp_res;
        e.cry = v.exp_cry;
        sb.push_back(e);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_num_a = $urandom;
        bus.i_num_b = $urandom;
        bus.i_cry   = 1'($urandom);
        check("busy_in_calc", 64'(bus.o_busy), 64'(1));
        check("ready_in_calc", 64'(bus.o_ready), 64'(0));
        cyc = 0;
        while (!bus.o_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'(WN));
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            check("res", 64'(bus.o_res), 64'(e.res));
            check("cry", 64'(bus.o_cry), 64'(e.cry));
        end
        if (v.hold > 0) begin
            held_res = bus.o_res;
            held_cry = bus.o_cry;
            for (int i = 0; i < v.hold; i++) begin
                bus.i_valid = 1'($urandom);
                bus.i_num_a = $urandom;
                bus.i_num_b = $urandom;
                @(negedge clk);
                check("bp_valid", 64'(bus.o_valid), 64'(1));
                check("bp_ready", 64'(bus.o_ready), 64'(0));
                check("bp_res", 64'(bus.o_res), 64'(held_res));
                check("bp_cry", 64'(bus.o_cry), 64'(held_cry));
            end
            bus.i_valid = 1'b0;
            bus.i_ready = 1'b1;
        end
        @(negedge clk);
        check("valid_drop", 64'(bus.o_valid), 64'(0));
        check("ready_back", 64'(bus.o_ready), 64'(1));
    endtask

    task automatic add_vec(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                           input logic sub, input int hold,
                           input logic [TW-1:0] er, input logic ec);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.hold = hold;
        v.exp_res = er; v.exp_cry = ec;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        vec_t v;
        int   cyc;
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_num_a = '0;
        bus.i_num_b = '0;
        bus.i_cry   = 1'b0;
`ifdef ADDER_MULTIWORD_SUB_EN
        bus.i_sub   = 1'b0;
`endif

        // Directed vectors with hand-derived results
        add_vec(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 0, 32'h0000_0003, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b1);
        add_vec(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 0, 32'h0100_0101, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 32'hFFFF_FFFF, 1'b1);
        add_vec(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 5, 32'h2222_2221, 1'b0);
`ifdef ADDER_MULTIWORD_SUB_EN
        add_vec(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 0, 32'h0000_000F, 1'b1);
        add_vec(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0);
        add_vec(32'h0000_0100, 32'h0000_0000, 1'b1, 1'b1, 0, 32'h0000_00FF, 1'b1);
`endif
        // Random vectors checked against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            v.a    = $urandom;
            v.b    = $urandom;
            v.cin  = 1'($urandom);
`ifdef ADDER_MULTIWORD_SUB_EN
            v.sub  = 1'($urandom);
`else
            v.sub  = 1'b0;
`endif
            v.hold = 0;
            e = model(v.a, v.b, v.cin, v.sub);
            add_vec(v.a, v.b, v.cin, v.sub, 0, e.res, e.cry);
        end

        // Reset for two cycles and check reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(bus.o_ready), 64'(1));
        check("rst_valid", 64'(bus.o_valid), 64'(0));
        check("rst_busy", 64'(bus.o_busy), 64'(0));
        check("rst_res", 64'(bus.o_res), 64'(0));
        check("rst_cry", 64'(bus.o_cry), 64'(0));

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset pulse on the edge that processes slice 2
        bus.i_ready = 1'b1;
        bus.i_num_a = 32'hFFFF_FFFF;
        bus.i_num_b = 32'hFFFF_FFFF;
        bus.i_cry   = 1'b1;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 64'(bus.o_ready), 64'(1));
        check("midrst_busy", 64'(bus.o_busy), 64'(0));
        check("midrst_res", 64'(bus.o_res), 64'(0));
        check("midrst_cry", 64'(bus.o_cry), 64'(0));
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.o_valid) cyc++;
        end
        check("midrst_no_valid", 64'(cyc), 64'(0));

        // One more operation after the aborted one must be clean
        v.a = 32'h8000_0000; v.b = 32'h8000_0000; v.cin = 1'b1; v.sub = 1'b0; v.hold = 0;
        v.exp_res = 32'h0000_0001; v.exp_cry = 1'b1;
        run_op(v);

        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
